// File: rtl/dct_pkg.sv
// Shared definitions for the DCT transpose stage: block size, counter width
// and the transpose scheduler state encoding.
package dct_pkg;

  localparam int unsigned DCT_N     = 8;
  localparam int unsigned DCT_CNT_W = 16;

  typedef enum logic [1:0] {
    TP_IDLE  = 2'd0,
    TP_RUN   = 2'd1,
    TP_DRAIN = 2'd2,
    TP_DONE  = 2'd3
  } tp_state_t;

endpackage

// File: rtl/tp_pingpong_ptr.sv
// Row/column index counter with a ping-pong bank bit; the wrap strobe marks
// the access to the last index of a block.
module tp_pingpong_ptr
  import dct_pkg::*;
#(
  parameter int unsigned N = DCT_N
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_adv,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_bank,
  output logic                 o_wrap_c
);

  localparam int unsigned        IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0]   LAST  = IDX_W'(N - 1);

  assign o_wrap_c = i_adv && (o_idx == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      o_idx  <= '0;
      o_bank <= 1'b0;
    end else if (i_adv) begin
      if (o_wrap_c) begin
        o_idx  <= '0;
        o_bank <= ~o_bank;
      end else begin
        o_idx <= o_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/transpose_scheduler.sv
// Sequencer for the 8x8 ping-pong transpose buffer: row writes in, column
// reads out, per-bank full tracking and per-frame block accounting.
module transpose_scheduler
  import dct_pkg::*;
#(
  parameter int unsigned N     = DCT_N,
  parameter int unsigned CNT_W = DCT_CNT_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [CNT_W-1:0]     i_num_blocks,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  output logic                 o_wr_en,
  output logic                 o_wr_bank,
  output logic [$clog2(N)-1:0] o_wr_row,
  input  logic                 i_out_ready,
  output logic                 o_rd_en,
  output logic                 o_rd_bank,
  output logic [$clog2(N)-1:0] o_rd_col,
  output logic                 o_out_valid,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [CNT_W-1:0]     o_blocks_out
);

  tp_state_t        state;
  tp_state_t        state_nxt;
  logic [CNT_W-1:0] num;
  logic [CNT_W-1:0] blocks_in;
  logic [1:0]       full;
  logic             start_go_c;
  logic             wr_wrap_c;
  logic             rd_wrap_c;
  logic             active_c;

  assign active_c   = (state == TP_RUN) || (state == TP_DRAIN);
  assign start_go_c = (state == TP_IDLE) && i_start && (i_num_blocks != '0);

  assign o_in_ready = (state == TP_RUN) && !full[o_wr_bank] && (blocks_in < num);
  assign o_wr_en    = i_in_valid && o_in_ready;
  assign o_rd_en    = active_c && full[o_rd_bank] && i_out_ready;
  assign o_busy     = (state != TP_IDLE);
  assign o_done     = (state == TP_DONE);

  tp_pingpong_ptr #(.N(N)) u_wr_ptr (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (start_go_c),
    .i_adv    (o_wr_en),
    .o_idx    (o_wr_row),
    .o_bank   (o_wr_bank),
    .o_wrap_c (wr_wrap_c)
  );

  tp_pingpong_ptr #(.N(N)) u_rd_ptr (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (start_go_c),
    .i_adv    (o_rd_en),
    .o_idx    (o_rd_col),
    .o_bank   (o_rd_bank),
    .o_wrap_c (rd_wrap_c)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= TP_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DRAIN exits while the last column's data is still presenting, so DONE
  // follows the final read by two cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      TP_IDLE:  if (i_start) state_nxt = (i_num_blocks == '0) ? TP_DONE : TP_RUN;
      TP_RUN:   if (blocks_in == num) state_nxt = TP_DRAIN;
      TP_DRAIN: if ((o_blocks_out == num) && !o_rd_en) state_nxt = TP_DONE;
      TP_DONE:  state_nxt = TP_IDLE;
      default:  state_nxt = TP_IDLE;
    endcase
  end

  // Full flags and block counters; the two banks can be set and cleared together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      num          <= '0;
      blocks_in    <= '0;
      o_blocks_out <= '0;
      full         <= 2'b00;
      o_out_valid  <= 1'b0;
    end else begin
      o_out_valid <= o_rd_en;
      if (start_go_c) begin
        num          <= i_num_blocks;
        blocks_in    <= '0;
        o_blocks_out <= '0;
        full         <= 2'b00;
      end else begin
        if (wr_wrap_c) begin
          full[o_wr_bank] <= 1'b1;
          blocks_in       <= blocks_in + CNT_W'(1);
        end
        if (rd_wrap_c) begin
          full[o_rd_bank] <= 1'b0;
          o_blocks_out    <= o_blocks_out + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_transpose_scheduler.sv
// Randomized scoreboard bench for transpose_scheduler against a block-count
// model of the ping-pong buffer.
module tb_transpose_scheduler;

  localparam int N     = 8;
  localparam int CNT_W = 16;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_start = 1'b0;
  logic [CNT_W-1:0] i_num_blocks = '0;
  logic             i_in_valid = 1'b0;
  logic             o_in_ready;
  logic             o_wr_en;
  logic             o_wr_bank;
  logic [2:0]       o_wr_row;
  logic             i_out_ready = 1'b0;
  logic             o_rd_en;
  logic             o_rd_bank;
  logic [2:0]       o_rd_col;
  logic             o_out_valid;
  logic             o_busy;
  logic             o_done;
  logic [CNT_W-1:0] o_blocks_out;

  always #5 i_clk = ~i_clk;

  transpose_scheduler #(.N(N), .CNT_W(CNT_W)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_num_blocks (i_num_blocks),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .o_wr_en      (o_wr_en),
    .o_wr_bank    (o_wr_bank),
    .o_wr_row     (o_wr_row),
    .i_out_ready  (i_out_ready),
    .o_rd_en      (o_rd_en),
    .o_rd_bank    (o_rd_bank),
    .o_rd_col     (o_rd_col),
    .o_out_valid  (o_out_valid),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_blocks_out (o_blocks_out)
  );

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int pv = 0;
  int pr = 0;

  // Expected write/read addresses encoded as bank*N + index.
  int wr_q[$];
  int rd_q[$];

  // Model: whole blocks written/read, frame activity and expected done cycle.
  int m_busy, m_num, m_written, m_read, m_done_cyc, m_prev_rd, m_rst_prev;
  int e_ready, e_rd, e_wr, e_addr, start_acc;

  always @(posedge i_clk) cycle <= cycle + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cycle, act, exp);
    end
  endtask

  task automatic model_clear();
    m_busy = 0; m_num = 0; m_written = 0; m_read = 0;
    m_done_cyc = -1; m_prev_rd = 0;
    wr_q.delete();
    rd_q.delete();
  endtask

  // Monitor: compares every cycle, then advances the model.
  initial begin
    model_clear();
    m_rst_prev = 1;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        model_clear();
        m_rst_prev = 1;
      end else begin
        start_acc = (i_start && !m_busy) ? 1 : 0;
        e_ready = (m_busy != 0 && m_written < m_num && (m_written - m_read) < 2) ? 1 : 0;
        e_rd    = (m_busy != 0 && m_written > m_read && i_out_ready) ? 1 : 0;
        e_wr    = (e_ready != 0 && i_in_valid) ? 1 : 0;

        chk("in_ready",   int'(o_in_ready),   e_ready);
        chk("wr_en",      int'(o_wr_en),      e_wr);
        chk("rd_en",      int'(o_rd_en),      e_rd);
        chk("out_valid",  int'(o_out_valid),  m_prev_rd);
        chk("busy",       int'(o_busy),       m_busy);
        chk("done",       int'(o_done),       (cycle == m_done_cyc) ? 1 : 0);
        chk("blocks_out", int'(o_blocks_out), m_read);
        if (m_rst_prev != 0)
          chk("ptrs_after_reset", int'({o_wr_bank, o_wr_row, o_rd_bank, o_rd_col}), 0);
        m_rst_prev = 0;

        if (e_wr != 0) begin
          if (wr_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL wr_unexpected cycle=%0d actual=write expected=none", cycle);
          end else begin
            e_addr = wr_q.pop_front();
            chk("wr_addr", int'({o_wr_bank, o_wr_row}), e_addr);
            if (e_addr % N == N - 1) m_written++;
          end
        end

        if (e_rd != 0) begin
          if (rd_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL rd_unexpected cycle=%0d actual=read expected=none", cycle);
          end else begin
            e_addr = rd_q.pop_front();
            chk("rd_addr", int'({o_rd_bank, o_rd_col}), e_addr);
            if (e_addr % N == N - 1) begin
              m_read++;
              if (m_read == m_num) m_done_cyc = cycle + 2;
            end
          end
        end
        m_prev_rd = e_rd;

        if (m_busy != 0 && cycle == m_done_cyc) begin
          m_busy = 0;
          m_done_cyc = -1;
        end

        if (start_acc != 0) begin
          m_busy = 1;
          if (i_num_blocks == '0) begin
            m_num = 0;
            m_written = m_read;
            m_done_cyc = cycle + 1;
          end else begin
            m_num = int'(i_num_blocks);
            m_written = 0;
            m_read = 0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
    i_start     = 1'b0;
    i_in_valid  = (int'($urandom_range(0, 99)) < pv);
    i_out_ready = (int'($urandom_range(0, 99)) < pr);
  endtask

  task automatic do_reset(input int k);
    step();
    i_rst = 1'b1;
    repeat (k) step();
    i_rst = 1'b0;
  endtask

  task automatic start_frame(input int n);
    for (int b = 0; b < n; b++) begin
      for (int r = 0; r < N; r++) begin
        wr_q.push_back((b % 2) * N + r);
        rd_q.push_back((b % 2) * N + r);
      end
    end
    step();
    i_start = 1'b1;
    i_num_blocks = CNT_W'(n);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    step();
    while (m_busy != 0 && k < budget) begin
      step();
      k++;
    end
    if (m_busy != 0) begin
      checks++; failures++;
      $display("FAIL frame_timeout cycle=%0d actual=busy expected=idle", cycle);
      do_reset(2);
    end
  endtask

  initial begin
    pv = 0; pr = 0;
    repeat (3) step();
    i_rst = 1'b0;
    repeat (3) step();

    // Single block at full throughput.
    pv = 100; pr = 100;
    start_frame(1);
    wait_idle(200);
    repeat (2) step();

    // Three blocks back to back.
    start_frame(3);
    wait_idle(300);

    // Downstream stalled: both banks fill, then drain bank 0 first.
    pv = 100; pr = 0;
    start_frame(4);
    repeat (30) step();
    pr = 100;
    wait_idle(500);

    // Empty frame.
    pv = 100; pr = 100;
    start_frame(0);
    wait_idle(20);

    // Reset after five rows, then a fresh frame.
    pv = 100; pr = 0;
    start_frame(2);
    repeat (5) step();
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    pr = 100;
    repeat (2) step();
    start_frame(1);
    wait_idle(200);

    // Random traffic with an ignored mid-frame start.
    for (int f = 0; f < 8; f++) begin
      pv = int'($urandom_range(30, 100));
      pr = int'($urandom_range(30, 100));
      start_frame(int'($urandom_range(1, 5)));
      repeat (6) step();
      if (f % 2 == 0) begin
        i_start = 1'b1;
        i_num_blocks = CNT_W'(7);
      end
      wait_idle(3000);
      repeat (int'($urandom_range(0, 3))) step();
    end

    repeat (3) step();
    chk("wr_q_drained", wr_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
